// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Imported by mem_stage and mem_align.
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT
    } state_e;

    localparam logic [3:0] BE_WORD  = 4'hF;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;

    // MEM/WB pipeline register contents; an all-zero value is a bubble.
    typedef struct packed {
        logic        memtoreg;
        logic        regwrite;
        logic [31:0] readdata;
        logic [31:0] aluresult;
        logic [4:0]  rd;
    } mwb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Single-port data-memory bus with a req/ready handshake.
// The stage is the master; the memory is the slave.
interface mem_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, rdata
    );

endinterface

// File: rtl/mem_align.sv
// Byte/word lane handling: store byte-enable and lane replication,
// load byte extraction with zero or sign extension.
module mem_align
    import mem_pkg::*;
(
    input  logic        bitype,
    input  logic        unsign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0] lane;

    always_comb begin
        lane = rdata[{addr_lo, 3'b000} +: 8];
        if (bitype) begin
            be        = BE_BYTE0 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = unsign ? {24'h0, lane} : {{24{lane[7]}}, lane};
        end else begin
            be        = BE_WORD;
            wdata     = store_data;
            load_data = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory bus FSM, stall generation and MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN turns unaligned word accesses into a misalign pulse.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    input  logic        zero_in,
    input  logic        bitype_in,
    input  logic        unsign_in,
    input  logic [31:0] aluresult_in,
    input  logic [31:0] writedata_in,
    input  logic [4:0]  rd_in,
    output logic        pcsrc,
    output logic        stall,
    mem_stage_if.master dmem,
    output logic        memtoreg_out,
    output logic        regwrite_out,
    output logic [31:0] readdata_out,
    output logic [31:0] aluresult_out,
    output logic [4:0]  rd_out,
    output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYC);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic             we_q;
    logic             bitype_q;
    logic             unsign_q;
    logic             memtoreg_q;
    logic             regwrite_q;
    logic [4:0]       rd_q;
    mwb_t             mwb_q;

    logic        access;
    logic        misalign_hit;
    logic        in_wait;
    logic        timeout;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic        cur_we;
    logic        cur_bitype;
    logic        cur_unsign;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] load_fmt;
    logic [31:0] ld_data;
    logic        req;
    mwb_t        mwb_now;
    mwb_t        mwb_lat;

    assign access  = memread_in | memwrite_in;
    assign in_wait = (state_q == WAIT);
    assign timeout = (cnt_q == CntMax);
    assign pcsrc   = branch_in & zero_in;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_hit = access & ~bitype_in & (aluresult_in[1:0] != 2'b00) & ~in_wait;
    assign misalign     = misalign_hit;
`else
    assign misalign_hit = 1'b0;
`endif

    // While waiting, the bus and formatting run from the latched copy of the access.
    always_comb begin
        cur_addr   = in_wait ? addr_q   : aluresult_in;
        cur_data   = in_wait ? data_q   : writedata_in;
        cur_we     = in_wait ? we_q     : memwrite_in;
        cur_bitype = in_wait ? bitype_q : bitype_in;
        cur_unsign = in_wait ? unsign_q : unsign_in;
    end

    mem_align u_align (
        .bitype     (cur_bitype),
        .unsign     (cur_unsign),
        .addr_lo    (cur_addr[1:0]),
        .store_data (cur_data),
        .rdata      (dmem.rdata),
        .be         (be_fmt),
        .wdata      (wdata_fmt),
        .load_data  (load_fmt)
    );

    assign ld_data = cur_we ? 32'h0 : load_fmt;

    always_comb begin
        req     = 1'b0;
        stall   = 1'b0;
        bus_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access && !misalign_hit) begin
                    req   = 1'b1;
                    stall = ~dmem.ready;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (!dmem.ready) begin
                    bus_err = timeout;
                    stall   = ~timeout;
                end
            end
            default: ;
        endcase
    end

    assign dmem.req   = req;
    assign dmem.we    = req & cur_we;
    assign dmem.addr  = {cur_addr[31:2], 2'b00};
    assign dmem.wdata = wdata_fmt;
    assign dmem.be    = be_fmt;

    always_comb begin
        mwb_now = '{memtoreg: memtoreg_in, regwrite: regwrite_in,
                    readdata: access ? ld_data : 32'h0,
                    aluresult: aluresult_in, rd: rd_in};
        mwb_lat = '{memtoreg: memtoreg_q, regwrite: regwrite_q, readdata: ld_data,
                    aluresult: addr_q, rd: rd_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            bitype_q   <= 1'b0;
            unsign_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            mwb_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!access) begin
                        mwb_q <= mwb_now;
                    end else if (misalign_hit) begin
                        mwb_q <= '0;
                    end else if (dmem.ready) begin
                        mwb_q <= mwb_now;
                    end else begin
                        addr_q     <= aluresult_in;
                        data_q     <= writedata_in;
                        we_q       <= memwrite_in;
                        bitype_q   <= bitype_in;
                        unsign_q   <= unsign_in;
                        memtoreg_q <= memtoreg_in;
                        regwrite_q <= regwrite_in;
                        rd_q       <= rd_in;
                        cnt_q      <= CNT_W'(1);
                        mwb_q      <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem.ready) begin
                        mwb_q   <= mwb_lat;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (timeout) begin
                        mwb_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        mwb_q <= '0;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memtoreg_out  = mwb_q.memtoreg;
    assign regwrite_out  = mwb_q.regwrite;
    assign readdata_out  = mwb_q.readdata;
    assign aluresult_out = mwb_q.aluresult;
    assign rd_out        = mwb_q.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: drives EX/MEM ops, models the memory latency
// and compares MEM/WB results against a scoreboard of expected values.
module tb_mem_stage;

    localparam int TO = 4;

    typedef struct packed {
        logic        memtoreg;
        logic        regwrite;
        logic [31:0] readdata;
        logic [31:0] aluresult;
        logic [4:0]  rd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        branch_in, memread_in, memwrite_in, memtoreg_in, regwrite_in;
    logic        zero_in, bitype_in, unsign_in;
    logic [31:0] aluresult_in, writedata_in;
    logic [4:0]  rd_in;
    logic        pcsrc, stall, memtoreg_out, regwrite_out, bus_err;
    logic [31:0] readdata_out, aluresult_out;
    logic [4:0]  rd_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    mem_stage_if dmem ();

    mem_stage #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_in     (branch_in),
        .memread_in    (memread_in),
        .memwrite_in   (memwrite_in),
        .memtoreg_in   (memtoreg_in),
        .regwrite_in   (regwrite_in),
        .zero_in       (zero_in),
        .bitype_in     (bitype_in),
        .unsign_in     (unsign_in),
        .aluresult_in  (aluresult_in),
        .writedata_in  (writedata_in),
        .rd_in         (rd_in),
        .pcsrc         (pcsrc),
        .stall         (stall),
        .dmem          (dmem),
        .memtoreg_out  (memtoreg_out),
        .regwrite_out  (regwrite_out),
        .readdata_out  (readdata_out),
        .aluresult_out (aluresult_out),
        .rd_out        (rd_out),
        .bus_err       (bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign      (misalign)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic bt, input logic us,
                                             input logic [1:0] a, input logic [31:0] w);
        logic [7:0] b;
        b = w[8*a +: 8];
        if (!bt) return w;
        return us ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    task automatic nop_inputs();
        branch_in = 0; memread_in = 0; memwrite_in = 0; memtoreg_in = 0; regwrite_in = 0;
        zero_in = 0; bitype_in = 0; unsign_in = 0;
        aluresult_in = 0; writedata_in = 0; rd_in = 0;
        dmem.ready = 0; dmem.rdata = 0;
    endtask

    task automatic check_mwb(input exp_t e);
        check_eq("mwb_memtoreg", {31'h0, memtoreg_out}, {31'h0, e.memtoreg});
        check_eq("mwb_regwrite", {31'h0, regwrite_out}, {31'h0, e.regwrite});
        check_eq("mwb_readdata", readdata_out, e.readdata);
        check_eq("mwb_aluresult", aluresult_out, e.aluresult);
        check_eq("mwb_rd", {27'h0, rd_out}, {27'h0, e.rd});
    endtask

    // Called just after a negedge; lat<0 means the memory never answers.
    task automatic run_op(input logic mr, input logic mw, input logic bt, input logic us,
                          input logic rw, input logic mtr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdat,
                          input logic [4:0] rd, input int lat);
        logic       acc;
        logic       to;
        exp_t       e;
        int         stalls, errs, cyc, exp_stall;
        bit         done;
        logic [3:0] exp_be;
        acc = mr | mw;
        to  = acc && (lat < 0);
        if (!acc)    e = '{memtoreg: mtr, regwrite: rw, readdata: 32'h0, aluresult: addr, rd: rd};
        else if (to) e = '0;
        else e = '{memtoreg: mtr, regwrite: rw,
                   readdata: mw ? 32'h0 : exp_load(bt, us, addr[1:0], rdat),
                   aluresult: addr, rd: rd};
        sb_q.push_back(e);
        exp_stall = !acc ? 0 : (to ? TO : lat);
        exp_be    = bt ? (4'b0001 << addr[1:0]) : 4'hF;

        memread_in = mr; memwrite_in = mw; bitype_in = bt; unsign_in = us;
        regwrite_in = rw; memtoreg_in = mtr; aluresult_in = addr; writedata_in = wd;
        rd_in = rd;
        stalls = 0; errs = 0; cyc = 0; done = 0;
        while (!done && cyc < 64) begin
            dmem.ready = (lat >= 0) && (cyc >= lat);
            dmem.rdata = dmem.ready ? rdat : $urandom;
            #1;
            if (cyc == 0) begin
                check_eq("bus_req", {31'h0, dmem.req}, {31'h0, acc});
                if (acc) begin
                    check_eq("bus_we", {31'h0, dmem.we}, {31'h0, mw});
                    check_eq("bus_addr", dmem.addr, {addr[31:2], 2'b00});
                    if (mw) begin
                        check_eq("bus_be", {28'h0, dmem.be}, {28'h0, exp_be});
                        check_eq("bus_wdata", dmem.wdata, bt ? {4{wd[7:0]}} : wd);
                    end
                end
            end
            if (stall) stalls++;
            if (bus_err) errs++;
            if (!stall) done = 1;
            @(negedge clk);
            cyc++;
        end
        check_eq("op_done", {31'h0, done}, 32'h1);
        check_eq("stall_cycles", stalls, exp_stall);
        check_eq("bus_err_pulses", errs, to ? 1 : 0);
        e = sb_q.pop_front();
        check_mwb(e);
        nop_inputs();
        #1;
        check_eq("req_idle", {31'h0, dmem.req}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        nop_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req", {31'h0, dmem.req}, 32'h0);
        check_eq("rst_stall", {31'h0, stall}, 32'h0);
        check_eq("rst_bus_err", {31'h0, bus_err}, 32'h0);
        check_mwb('0);
        rst_n = 1;
        @(negedge clk);

        // mr mw bt us rw mtr addr wd rdata rd lat
        run_op(0, 1, 0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 32'h0, 5'd0, 0);   // sw zero-wait
        run_op(1, 0, 1, 0, 1, 1, 32'h103, 32'h0, 32'h80FF1234, 5'd5, 3);   // lb
        run_op(1, 0, 1, 1, 1, 1, 32'h103, 32'h0, 32'h80FF1234, 5'd6, 3);   // lbu
        run_op(0, 1, 1, 0, 0, 0, 32'h202, 32'hA5, 32'h0, 5'd0, 2);         // sb
        run_op(1, 0, 0, 0, 1, 1, 32'h104, 32'h0, 32'h0, 5'd9, -1);         // lw timeout
        run_op(0, 0, 0, 0, 1, 0, 32'h1234, 32'h0, 32'h0, 5'd7, 0);         // alu op
        run_op(1, 0, 0, 0, 1, 1, 32'h108, 32'h0, 32'h12345678, 5'd8, 1);   // lw
        run_op(1, 0, 1, 0, 1, 1, 32'h101, 32'h0, 32'h00007F00, 5'd10, 0);  // lb positive
        for (int i = 0; i < 8; i++) begin
            logic       bt, mw;
            logic [1:0] lo;
            bt = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            lo = bt ? 2'($urandom_range(0, 3)) : 2'b00;
            run_op(~mw, mw, bt, 1'($urandom_range(0, 1)), ~mw, ~mw,
                   32'h300 + 32'(i * 4) + {30'h0, lo}, $urandom, $urandom,
                   5'(i + 11), $urandom_range(0, 3));
        end

        // Branch resolution during a pending load, then reset mid-WAIT.
        memread_in = 1; bitype_in = 1; regwrite_in = 1; memtoreg_in = 1;
        aluresult_in = 32'h400; rd_in = 5'd3; branch_in = 1; zero_in = 1;
        dmem.ready = 0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("beq_pcsrc", {31'h0, pcsrc}, 32'h1);
        check_eq("beq_stall", {31'h0, stall}, 32'h1);
        check_eq("beq_req", {31'h0, dmem.req}, 32'h1);
        zero_in = 0;
        #1;
        check_eq("beq_pcsrc_nz", {31'h0, pcsrc}, 32'h0);
        nop_inputs();
        rst_n = 0;
        #1;
        check_eq("midrst_req", {31'h0, dmem.req}, 32'h0);
        check_eq("midrst_stall", {31'h0, stall}, 32'h0);
        check_mwb('0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run_op(1, 0, 0, 0, 1, 1, 32'h500, 32'h0, 32'h0, 5'd4, -1);         // counter restarted
        run_op(1, 0, 1, 1, 1, 1, 32'h502, 32'h0, 32'hCAFEBABE, 5'd2, 1);   // lbu after reset

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage; consumes the EX/MEM register outputs (ALU result, store data, control bits, byte-type/unsigned flags).
- Drives a single-port data-memory bus with a req/ready handshake and formats byte/word loads and stores.
- Resolves branch-taken, stalls the front of the pipeline while memory is busy, and owns the MEM/WB pipeline register feeding writeback and forwarding.

Parameters:
- TIMEOUT_CYC, 16: maximum WAIT cycles before a bus access is abandoned; range 1..255.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- branch_in, memread_in, memwrite_in, memtoreg_in, regwrite_in, zero_in, bitype_in, unsign_in  in  1 each  EX/MEM control bits
- aluresult_in  in  32  effective address or ALU result
- writedata_in  in  32  store data (rs2 after forwarding)
- rd_in  in  5  destination register
- pcsrc  out  1  branch taken = branch_in & zero_in (combinational)
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- dmem_req, dmem_we  out  1  bus request / write enable
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access complete this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready=1 and dmem_we=0
- memtoreg_out, regwrite_out  out  1  MEM/WB control bits
- readdata_out, aluresult_out  out  32  MEM/WB data
- rd_out  out  5  MEM/WB destination
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE, counter 0, all MEM/WB outputs 0, bus_err 0, dmem_req 0.
- access = memread_in | memwrite_in; memwrite has priority if both are set.
- FSM IDLE:
  - no access: stall=0; MEM/WB captures the inputs on every clk; readdata_out=0.
  - access: dmem_req=1 combinationally; address, data and enables are driven from the inputs.
  - If dmem_ready is also 1, the access is zero-wait: stall=0 and MEM/WB captures the formatted result.
  - Otherwise stall=1; latch addr, wdata, be, we and all controls; counter=1; go to WAIT.
- FSM WAIT:
  - dmem_req=1 and the bus is driven from the latched copies.
  - stall=1 until completion.
  - MEM/WB loads a bubble each cycle (regwrite_out=0, memtoreg_out=0).
- Completion (WAIT, dmem_ready=1):
  - stall=0; MEM/WB captures the latched controls and the formatted read data; go to IDLE.
- Timeout (WAIT, counter==TIMEOUT_CYC, dmem_ready=0):
  - stall=0; bus_err=1 for that cycle.
  - MEM/WB captures a bubble: regwrite_out=0, readdata_out=0.
  - Go to IDLE. dmem_req drops in the following cycle.
- Store formatting:
  - bitype=1: be = 4'b0001 << addr[1:0]; wdata = {4{writedata[7:0]}}.
  - bitype=0: be = 4'hF; wdata = writedata.
- Load formatting: byte = dmem_rdata[8*addr[1:0] +: 8].
  - unsign=1: zero-extend the byte.
  - unsign=0: sign-extend the byte.
  - bitype=0: the full word.
- dmem_ready while not requesting: ignored.
- pcsrc is independent of stall. EX/MEM holds the branch instruction only while stalled, so the hazard unit gates pcsrc.
- Reset asserted mid-WAIT: return to IDLE immediately and drop dmem_req; the access is abandoned.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - A word access (bitype=0) with addr[1:0]!=0 issues no bus request.
  - The block completes in the IDLE cycle with stall=0 and a bubble into MEM/WB.
  - Adds output port misalign, a one-cycle pulse.
- Undefined: the low address bits are silently dropped; there is no misalign port.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, WAIT};
  - localparam BE_WORD=4'hF;
  - localparam BE_BYTE0=4'b0001.
- Sub-module mem_align: combinational store lane/byte-enable generation and load extract/extend; instantiated once.
- mem_stage holds the FSM, counter, latches and MEM/WB register.

Test Plan:
- sw, addr 0x100, data 0xDEADBEEF, ready in same cycle -> be=F, wdata=0xDEADBEEF, stall never 1, regwrite_out=0.
- lb, addr 0x103, rdata 0x80FF1234, ready after 3 cycles -> stall high for exactly 3 cycles; readdata_out=0xFFFFFF80 with regwrite_out=1 one cycle after ready.
- lbu, same address and data -> readdata_out=0x00000080.
- sb, addr 0x202, data 0x000000A5 -> be=4'b0100, wdata=0xA5A5A5A5, dmem_addr=0x200.
- lw with ready never asserted, TIMEOUT_CYC=4 -> stall 4 cycles, bus_err pulses once, regwrite_out=0, FSM back in IDLE.
- beq with zero_in=1 during a pending load wait, then rst_n low mid-WAIT -> pcsrc=1 combinationally; after reset, dmem_req=0 and all MEM/WB outputs are 0.
